// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_pkg
//  Purpose  : Shared mode encodings and code-conversion helpers for the
//             parametrised multi-mode counter.
//  Revision : 1.0 - initial release
// ============================================================================
package counter_pkg;

   // Counter code selection; the reserved encoding behaves as binary.
   localparam logic [1:0] MODE_BIN  = 2'b00;
   localparam logic [1:0] MODE_JOHN = 2'b01;
   localparam logic [1:0] MODE_GRAY = 2'b10;
   localparam logic [1:0] MODE_RSVD = 2'b11;

   // Widest counter the width-generic helpers below can handle.
   localparam int MAX_WIDTH = 32;

   // Binary to reflected Gray code.
   function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // A Johnson code of 'width' bits is 0..01..1 or 1..10..0, i.e. it has at
   // most one transition between adjacent bits inside the active width.
   function automatic logic is_johnson_valid(input logic [MAX_WIDTH-1:0] v,
                                             input int                   width);
      int edges;
      edges = 0;
      for (int i = 0; i < MAX_WIDTH - 1; i++) begin
         if ((i < width - 1) && (v[i] != v[i+1])) begin
            edges++;
         end
      end
      return (edges <= 1);
   endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/gray2bin.sv
`default_nettype none
// ============================================================================
//  Module   : gray2bin
//  Purpose  : Combinational Gray-to-binary converter (XOR prefix chain from
//             the MSB downwards).
//  Revision : 1.0 - initial release
// ============================================================================
module gray2bin #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] gray,
   output logic [WIDTH-1:0] bin
);

   // Each binary bit is the XOR of all Gray bits at or above its position.
   always_comb begin
      logic acc;
      acc = 1'b0;
      bin = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         acc    = acc ^ gray[i];
         bin[i] = acc;
      end
   end

endmodule : gray2bin
`default_nettype wire

// File: rtl/param_sync_counter.sv
`default_nettype none
// ============================================================================
//  Module   : param_sync_counter
//  Purpose  : Parametrised up/down counter with binary, Johnson and Gray
//             output codes, parallel load, enable, wrap-or-saturate and a
//             combinational terminal-count flag.
//  Revision : 1.0 - initial release
// ============================================================================
module param_sync_counter
   import counter_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int SAT_DEFAULT = 0   // recommended tie-off value for sat
) (
   input  logic             clk,
   input  logic             rst,       // asynchronous, active low
   input  logic             en,
   input  logic             up_dn,
   input  logic [1:0]       mode,
   input  logic             sat,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] out,
   output logic             tc
);

   // Reject nonsensical parameterisations at elaboration time.
   if ((WIDTH < 2) || (WIDTH > MAX_WIDTH) || (SAT_DEFAULT < 0) || (SAT_DEFAULT > 1)) begin : g_param_check
      $error("param_sync_counter: WIDTH must be 2..%0d and SAT_DEFAULT 0 or 1", MAX_WIDTH);
   end

   logic [WIDTH-1:0] r_bin;     // binary shadow used by binary and Gray modes
   logic [WIDTH-1:0] r_out;     // registered output code
   logic [1:0]       r_mode;    // mode seen on the previous edge

   logic             w_mode_chg;
   logic [WIDTH-1:0] w_term;
   logic [WIDTH-1:0] w_load_bin;
   logic [WIDTH-1:0] w_bin_step;
   logic [WIDTH-1:0] w_john_step;
   logic             w_john_cur_ok;
   logic             w_john_load_ok;
   logic             w_tc;

   assign out        = r_out;
   assign w_mode_chg = (mode != r_mode);

   // Gray loads are tracked internally in binary so counting continues correctly.
   gray2bin #(
      .WIDTH (WIDTH)
   ) u_load_g2b (
      .gray (load_val),
      .bin  (w_load_bin)
   );

   assign w_john_cur_ok  = is_johnson_valid(MAX_WIDTH'(r_out), WIDTH);
   assign w_john_load_ok = is_johnson_valid(MAX_WIDTH'(load_val), WIDTH);
   assign w_bin_step     = up_dn ? (r_bin + WIDTH'(1)) : (r_bin - WIDTH'(1));

   // Johnson successor; any corrupted pattern falls back to the zero state.
   always_comb begin
      w_john_step = '0;
      if (w_john_cur_ok) begin
         if (up_dn) begin
            w_john_step = {r_out[WIDTH-2:0], ~r_out[WIDTH-1]};
         end else begin
            w_john_step = {~r_out[0], r_out[WIDTH-1:1]};
         end
      end
   end

   // Terminal value: zero when counting down; last code of the sequence when up.
   always_comb begin
      w_term = '0;
      if (up_dn) begin
         case (r_mode)
            MODE_JOHN, MODE_GRAY: w_term = {1'b1, {(WIDTH-1){1'b0}}};
            default:              w_term = '1;
         endcase
      end
   end

   // Flag is suppressed in reset, on load, when idle and on a mode-change edge.
   assign w_tc = rst & en & ~load & ~w_mode_chg & (r_out == w_term);
   assign tc   = w_tc;

   // Next-state: mode change > load > enabled count (unless saturated) > hold.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_bin  <= '0;
         r_out  <= '0;
         r_mode <= MODE_BIN;
      end else begin
         r_mode <= mode;
         if (w_mode_chg) begin
            r_bin <= '0;
            r_out <= '0;
         end else if (load) begin
            case (r_mode)
               MODE_JOHN: begin
                  r_bin <= '0;
                  r_out <= w_john_load_ok ? load_val : '0;
               end
               MODE_GRAY: begin
                  r_bin <= w_load_bin;
                  r_out <= load_val;
               end
               MODE_BIN, MODE_RSVD: begin
                  r_bin <= load_val;
                  r_out <= load_val;
               end
               default: begin
                  r_bin <= load_val;
                  r_out <= load_val;
               end
            endcase
         end else if (en && !(sat && w_tc)) begin
            case (r_mode)
               MODE_JOHN: begin
                  r_out <= w_john_step;
               end
               MODE_GRAY: begin
                  r_bin <= w_bin_step;
                  r_out <= WIDTH'(bin2gray(MAX_WIDTH'(w_bin_step)));
               end
               default: begin
                  r_bin <= w_bin_step;
                  r_out <= w_bin_step;
               end
            endcase
         end
      end
   end

endmodule : param_sync_counter
`default_nettype wire

// File: tb/tb_param_sync_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_param_sync_counter
//  Purpose  : Directed self-checking bench for param_sync_counter (WIDTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_param_sync_counter;

   localparam int WIDTH       = 4;
   localparam int SAT_DEFAULT = 0;

   logic             clk = 1'b0;
   logic             rst;
   logic             en;
   logic             up_dn;
   logic [1:0]       mode;
   logic             sat;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] out;
   logic             tc;

   int n_checks = 0;
   int n_errors = 0;

   param_sync_counter #(
      .WIDTH       (WIDTH),
      .SAT_DEFAULT (SAT_DEFAULT)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .up_dn    (up_dn),
      .mode     (mode),
      .sat      (sat),
      .load     (load),
      .load_val (load_val),
      .out      (out),
      .tc       (tc)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
      end
   endtask

   logic [3:0] john_dn [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                               4'b0111, 4'b0011, 4'b0001, 4'b0000};

   initial begin
      logic [3:0] cur;

      // Reset with enable and down-count asserted: tc must still be 0.
      rst      = 1'b0;
      en       = 1'b1;
      up_dn    = 1'b0;
      mode     = 2'b00;
      sat      = SAT_DEFAULT[0];
      load     = 1'b0;
      load_val = '0;
      #1;
      check("reset_out", 32'(out), 32'h0);
      check("reset_tc", 32'(tc), 32'h0);
      tick_n(2);
      check("reset_hold_out", 32'(out), 32'h0);

      @(negedge clk);
      rst   = 1'b1;
      up_dn = 1'b1;
      #1;

      // Binary up, wrap: 0..15 then 0, tc only at 15.
      for (int k = 0; k < 16; k++) begin
         check($sformatf("bin_up_tc_%0d", k), 32'(tc), (k == 15) ? 32'h1 : 32'h0);
         tick();
         check($sformatf("bin_up_out_%0d", k + 1), 32'(out), 32'((k + 1) % 16));
      end

      // Johnson down from zero.
      mode  = 2'b01;
      up_dn = 1'b0;
      #1;
      check("john_chg_tc", 32'(tc), 32'h0);
      tick();
      check("john_chg_out", 32'(out), 32'h0);
      cur = 4'b0000;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("john_dn_tc_%0d", k), 32'(tc), (cur == 4'b0000) ? 32'h1 : 32'h0);
         tick();
         check($sformatf("john_dn_out_%0d", k), 32'(out), 32'(john_dn[k]));
         cur = john_dn[k];
      end

      // Binary saturate at 15, then reverse direction.
      mode  = 2'b00;
      up_dn = 1'b1;
      tick();
      check("bin_chg_out", 32'(out), 32'h0);
      sat      = 1'b1;
      load     = 1'b1;
      load_val = 4'd14;
      #1;
      check("load_tc", 32'(tc), 32'h0);
      tick();
      check("sat_load_out", 32'(out), 32'd14);
      load = 1'b0;
      #1;
      check("sat_14_tc", 32'(tc), 32'h0);
      tick();
      check("sat_15_out", 32'(out), 32'd15);
      check("sat_15_tc", 32'(tc), 32'h1);
      tick();
      check("sat_hold1_out", 32'(out), 32'd15);
      tick();
      check("sat_hold2_out", 32'(out), 32'd15);
      check("sat_hold2_tc", 32'(tc), 32'h1);
      up_dn = 1'b0;
      #1;
      check("sat_dn_tc", 32'(tc), 32'h0);
      tick();
      check("sat_dn_14", 32'(out), 32'd14);
      tick();
      check("sat_dn_13", 32'(out), 32'd13);
      sat = SAT_DEFAULT[0];

      // Gray mode load and count, then wrap from Gray(15).
      mode  = 2'b10;
      up_dn = 1'b1;
      tick();
      check("gray_chg_out", 32'(out), 32'h0);
      load     = 1'b1;
      load_val = 4'b0110;
      tick();
      check("gray_load_out", 32'(out), 32'b0110);
      load = 1'b0;
      tick();
      check("gray_up1_out", 32'(out), 32'b0111);
      tick();
      check("gray_up2_out", 32'(out), 32'b0101);
      load     = 1'b1;
      load_val = 4'b1000;
      tick();
      load = 1'b0;
      #1;
      check("gray_term_tc", 32'(tc), 32'h1);
      tick();
      check("gray_wrap_out", 32'(out), 32'h0);

      // Johnson loads: invalid pattern gives zero, valid pattern is taken.
      mode = 2'b01;
      tick();
      load     = 1'b1;
      load_val = 4'b0101;
      tick();
      check("john_bad_load", 32'(out), 32'h0);
      load_val = 4'b0111;
      tick();
      check("john_good_load", 32'(out), 32'b0111);
      load = 1'b0;
      tick();
      check("john_up_out", 32'(out), 32'b1111);

      // Binary to 9, then a mode change clears and suppresses tc.
      mode = 2'b00;
      tick();
      tick_n(9);
      check("bin_nine", 32'(out), 32'd9);
      mode = 2'b01;
      #1;
      check("chg_tc", 32'(tc), 32'h0);
      tick();
      check("chg_out", 32'(out), 32'h0);
      check("chg_after_tc", 32'(tc), 32'h0);
      tick();
      check("chg_first", 32'(out), 32'b0001);

      // Asynchronous reset in the middle of a count.
      mode = 2'b00;
      tick();
      tick_n(7);
      check("rst_pre_seven", 32'(out), 32'd7);
      #2;
      rst = 1'b0;
      #1;
      check("rst_async_out", 32'(out), 32'h0);
      check("rst_async_tc", 32'(tc), 32'h0);
      tick_n(2);
      check("rst_held_out", 32'(out), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      check("rst_resume_1", 32'(out), 32'd1);
      tick();
      check("rst_resume_2", 32'(out), 32'd2);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule : tb_param_sync_counter
`default_nettype wire

// File: doc/param_sync_counter.md
Name: param_sync_counter

Overview:
- Parametrised, multi-mode synchronous up/down counter.
- Generalises the team's fixed 4-bit counter: configurable width, binary/Johnson/Gray code modes, direction control, parallel load, enable, wrap-or-saturate, terminal-count flag.
- Drop-in sequencing/timing source for lab datapaths; one clock domain.

Parameters:
WIDTH, 4, counter/output width in bits (>= 2)
SAT_DEFAULT, 0, unused-at-runtime documentation default for sat port (bench ties sat to this)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  count enable
up_dn  input  1  1 = count up, 0 = count down
mode  input  2  00 binary, 01 Johnson, 10 Gray, 11 reserved (treated as binary)
sat  input  1  1 = saturate at terminal value, 0 = wrap
load  input  1  synchronous parallel load strobe
load_val  input  WIDTH  value to load, expressed in the current mode's code
out  output  WIDTH  current count in the selected code
tc  output  1  terminal-count flag (combinational)

Behaviour:
- Clock/reset: clk rising edge; rst low asynchronously clears all state: out = 0, internal binary register = 0, registered mode = 00, tc = 0 while in reset.
- Per-edge priority: rst > mode change > load > en > hold.
- Mode change: registered copy of mode compared each cycle; if mode differs, state clears to 0 on that edge regardless of load/en; registered mode updates. Latency 1 cycle.
- Load: out = load_val next edge.
  - Johnson: load_val not a valid Johnson code (not of form 0..01..1 or 1..10..0) -> loads 0.
  - Gray: load_val converted Gray-to-binary internally; out reflects load_val exactly.
- Count (en = 1, no load):
  - Binary: +1 / -1 modulo 2^WIDTH.
  - Johnson (2*WIDTH states):
    - up: shift left, LSB <= ~MSB (0000 -> 0001 -> 0011 -> 0111 -> 1111 -> 1110 -> 1100 -> 1000 -> 0000).
    - down: shift right, MSB <= ~LSB (exact reverse).
    - Invalid state from any cause: next state 0 (self-correcting).
  - Gray: internal binary register +/-1; out = bin ^ (bin >> 1), registered (no glitch path from adder to out).
- Terminal value:
  - down, all modes: 0.
  - up, binary: all ones.
  - up, Johnson: MSB-only (1000).
  - up, Gray: Gray(all ones) = MSB-only.
- tc = en & ~load & (out == terminal for current up_dn and registered mode); 0 during mode-change cycle.
- Saturate: sat = 1 and tc = 1 -> hold on edge; sat = 0 -> wrap to next code in sequence.
- up_dn change mid-count: takes effect on next edge, no extra latency, no state disturbance.
- en = 0: hold; tc = 0.
- Reset mid-operation: immediate clear, no partial update; first count after release is from 0.

Decomposition:
- Package counter_pkg: mode constants MODE_BIN, MODE_JOHN, MODE_GRAY, MODE_RSVD; functions is_johnson_valid, bin2gray.
- Sub-module gray2bin (WIDTH-parametrised, combinational XOR prefix chain) used on load path.
- Remaining next-state logic in one always block.

Test Plan:
- WIDTH=4, binary, up, sat=0, en=1 from reset: 0..15 then 0; tc high only at 15.
- Johnson, down, from reset: 0000, 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; tc at each 0000.
- Binary up, sat=1, load 14: 14, 15, 15, 15 (tc held 1); switch up_dn=0: 14, 13.
- Gray mode: load 0110 (bin 4), up: 0110 -> 0111 -> 0101; Johnson load 0101 (invalid) -> out 0000.
- Count to 9 in binary, change mode to Johnson: next edge out = 0000, tc = 0; then 0001.
- Pulse rst low between edges at count 7: out = 0 immediately; asserted through edges holds 0; release resumes 1, 2...
